// File: rtl/dmg_dma_pkg.sv
// Shared types and defaults for the OAM DMA engine.
package dmg_dma_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, RUN} dma_state_t;

    localparam int unsigned DMA_LEN_DEF    = 160;
    localparam int unsigned SETUP_MCYC_DEF = 1;
    localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
    localparam logic [2:0]  VRAM_PAGE_HI   = 3'b100;

endpackage

// File: rtl/oam_dma_counter.sv
// Byte counter for the OAM DMA copy: clear, advance, and a terminal flag at the last byte.
module oam_dma_counter
    import dmg_dma_pkg::*;
#(
    parameter int unsigned DMA_LEN = DMA_LEN_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clear,
    input  logic       i_advance,
    output logic [7:0] o_cnt,
    output logic       o_term
);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= 8'd0;
        end else if (i_clear) begin
            r_cnt <= 8'd0;
        end else if (i_advance) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_term = (r_cnt == 8'(DMA_LEN - 1));

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA initiator: FF46 write latches a source page, then copies DMA_LEN bytes into OAM,
// one byte per M-cycle, after SETUP_MCYC setup M-cycles.
module oam_dma_ctrl
    import dmg_dma_pkg::*;
#(
    parameter int unsigned DMA_LEN    = DMA_LEN_DEF,
    parameter int unsigned SETUP_MCYC = SETUP_MCYC_DEF,
    parameter logic [15:0] REG_ADDR   = DMA_REG_ADDR
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mcyc,
    input  logic [15:0] i_cpu_a,
    input  logic [7:0]  i_cpu_d,
    input  logic        i_cpu_wr,
    input  logic        i_cpu_rd,
    output logic [7:0]  o_reg_q,
    output logic        o_reg_oe,
    output logic [15:0] o_dma_a,
    output logic        o_dma_run,
    output logic        o_oam_addr_ndma,
    output logic        o_vram_to_oam,
    output logic        o_dma_ext,
    output logic        o_dma_wr
);

    dma_state_t  r_state;
    logic [7:0]  r_src;
    logic [7:0]  r_src_act;
    logic [7:0]  r_setup;
    logic        r_pend;
    logic        r_run;
    logic        r_vram;
    logic        r_wr;
    logic [15:0] r_dma_a;

    logic        w_reg_wr;
    logic        w_start;
    logic        w_byte;
    logic [7:0]  w_cnt;
    logic        w_term;

    assign w_reg_wr = i_cpu_wr && (i_cpu_a == REG_ADDR);
    // A pending trigger pre-empts any byte on the same M-cycle, which is what aborts a copy.
    assign w_start  = i_mcyc && r_pend;
    assign w_byte   = i_mcyc && !r_pend &&
                      (((r_state == SETUP) && (r_setup <= 8'd1)) || (r_state == RUN));

    oam_dma_counter #(
        .DMA_LEN (DMA_LEN)
    ) u_counter (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_start),
        .i_advance (w_byte),
        .o_cnt     (w_cnt),
        .o_term    (w_term)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_src     <= 8'hFF;
            r_src_act <= 8'hFF;
            r_setup   <= 8'd0;
            r_pend    <= 1'b0;
            r_run     <= 1'b0;
            r_vram    <= 1'b0;
            r_wr      <= 1'b0;
            r_dma_a   <= 16'hFF00;
        end else begin
            r_wr <= 1'b0;
            if (w_reg_wr) begin
                r_src  <= i_cpu_d;
                r_pend <= 1'b1;
            end else if (w_start) begin
                r_pend <= 1'b0;
            end

            if (w_start) begin
                r_state   <= SETUP;
                r_setup   <= 8'(SETUP_MCYC);
                r_src_act <= r_src;
                r_run     <= 1'b1;
                r_vram    <= (r_src[7:5] == VRAM_PAGE_HI);
            end else if (w_byte) begin
                r_wr    <= 1'b1;
                r_dma_a <= {r_src_act, w_cnt};
                r_setup <= 8'd0;
                r_state <= w_term ? IDLE : RUN;
            end else if (i_mcyc && (r_state == SETUP)) begin
                r_setup <= r_setup - 8'd1;
            end else if (r_state == IDLE) begin
                // Run drops one clk after the final write strobe.
                r_run  <= 1'b0;
                r_vram <= 1'b0;
            end
        end
    end

    assign o_reg_q         = r_src;
    assign o_reg_oe        = i_cpu_rd && (i_cpu_a == REG_ADDR);
    assign o_dma_a         = r_dma_a;
    assign o_dma_run       = r_run;
    assign o_oam_addr_ndma = !r_run;
    assign o_vram_to_oam   = r_vram;
    assign o_dma_ext       = r_run && !r_vram;
    assign o_dma_wr        = r_wr;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: expected OAM writes queued at stimulus, checked by a monitor.
module tb_oam_dma_ctrl;

    typedef struct {
        logic [15:0] a;
        logic        vram;
        logic        ext;
        int          gap;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        mcyc;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  reg_q;
    logic        reg_oe;
    logic [15:0] dma_a;
    logic        dma_run;
    logic        oam_addr_ndma;
    logic        vram_to_oam;
    logic        dma_ext;
    logic        dma_wr;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_mcyc, n_wr, n_fall, last_wr_mcyc;
    logic run_q;
    logic mcyc_en;
    int   div;

    oam_dma_ctrl u_dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_mcyc          (mcyc),
        .i_cpu_a         (cpu_a),
        .i_cpu_d         (cpu_d),
        .i_cpu_wr        (cpu_wr),
        .i_cpu_rd        (cpu_rd),
        .o_reg_q         (reg_q),
        .o_reg_oe        (reg_oe),
        .o_dma_a         (dma_a),
        .o_dma_run       (dma_run),
        .o_oam_addr_ndma (oam_addr_ndma),
        .o_vram_to_oam   (vram_to_oam),
        .o_dma_ext       (dma_ext),
        .o_dma_wr        (dma_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // M-cycle strobe: one clk high every four clks while enabled.
    initial begin
        mcyc = 1'b0;
        div  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mcyc_en) begin
                mcyc = (div == 3);
                div  = (div + 1) % 4;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_run(input logic [7:0] src, input int n, input int first_gap,
                            input logic vram);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.a    = {src, 8'(i)};
            e.vram = vram;
            e.ext  = !vram;
            e.gap  = (i == 0) ? first_gap : 1;
            q.push_back(e);
        end
    endtask

    // Monitor: pops the scoreboard on every OAM write strobe.
    initial begin
        exp_t e;
        int   gap;
        run_q = 1'b0; n_mcyc = 0; n_wr = 0; n_fall = 0; last_wr_mcyc = 0;
        forever begin
            @(negedge clk);
            if (mcyc) n_mcyc++;
            if (run_q && !dma_run) n_fall++;
            run_q = dma_run;
            if (dma_wr) begin
                n_wr++;
                gap = n_mcyc - last_wr_mcyc;
                last_wr_mcyc = n_mcyc;
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected dma_wr: dma_a=%h, required no write", dma_a);
                end else begin
                    e = q.pop_front();
                    check("wr dma_a", dma_a, e.a);
                    check("wr vram_to_oam", vram_to_oam, e.vram);
                    check("wr dma_ext", dma_ext, e.ext);
                    check("wr dma_run", dma_run, 1);
                    if (e.gap != 0) check("wr mcyc gap", gap, e.gap);
                end
            end
        end
    end

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cpu_a = a; cpu_d = d; cpu_wr = 1'b1;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
    endtask

    task automatic wait_mcyc(input string name);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mcyc) break;
        end
        if (k == 20) begin
            n_checks++; n_fail++;
            $display("FAIL %s: mcyc not seen within 20 clk, required a strobe", name);
        end
    endtask

    task automatic wait_done(input string name);
        int   k;
        logic last;
        for (k = 0; k < 40 && !dma_run; k++) @(negedge clk);
        check({name, " run rises"}, dma_run, 1);
        last = 1'b0;
        for (k = 0; k < 3000; k++) begin
            last = dma_wr;
            @(negedge clk);
            if (!dma_run) break;
        end
        check({name, " run falls in budget"}, dma_run, 0);
        check({name, " wr just before fall"}, last, 1);
        check({name, " scoreboard drained"}, q.size(), 0);
    endtask

    initial begin
        int   base, f0, k;
        logic bad;
        reset = 1'b1; mcyc_en = 1'b1;
        cpu_a = 16'h0000; cpu_d = 8'h00; cpu_wr = 1'b0; cpu_rd = 1'b0;
        #2;
        check("rst dma_run", dma_run, 0);
        check("rst ndma", oam_addr_ndma, 1);
        check("rst dma_a", dma_a, 16'hFF00);
        check("rst reg_q", reg_q, 8'hFF);
        check("rst vram_to_oam", vram_to_oam, 0);
        check("rst dma_ext", dma_ext, 0);
        check("rst dma_wr", dma_wr, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("idle after reset", dma_run, 0);

        // 1: WRAM-page copy, latency and ordering
        push_run(8'hC1, 160, 0, 1'b0);
        cpu_write(16'hFF46, 8'hC1);
        wait_mcyc("t1 trigger");
        @(negedge clk);
        check("t1 run after trigger mcyc", dma_run, 1);
        check("t1 no wr in setup", dma_wr, 0);
        check("t1 ndma low", oam_addr_ndma, 0);
        wait_mcyc("t1 setup");
        @(negedge clk);
        check("t1 first wr at 2nd mcyc", dma_wr, 1);
        wait_done("t1");
        check("t1 ndma after", oam_addr_ndma, 1);
        check("t1 dma_a holds", dma_a, 16'hC19F);
        check("t1 ext after", dma_ext, 0);

        // 2: VRAM-page copy and readback
        push_run(8'h80, 160, 0, 1'b1);
        cpu_write(16'hFF46, 8'h80);
        cpu_a = 16'hFF46; cpu_rd = 1'b1;
        #1;
        check("t2 reg_oe", reg_oe, 1);
        check("t2 reg_q", reg_q, 8'h80);
        cpu_rd = 1'b0;
        wait_done("t2");
        check("t2 vram after", vram_to_oam, 0);

        // 3: restart at byte 50
        base = n_wr; f0 = n_fall;
        push_run(8'hC0, 50, 0, 1'b0);
        push_run(8'hD0, 160, 2, 1'b0);
        cpu_write(16'hFF46, 8'hC0);
        for (k = 0; k < 1000 && n_wr < base + 50; k++) @(negedge clk);
        cpu_write(16'hFF46, 8'hD0);
        wait_done("t3");
        check("t3 total bytes", n_wr - base, 210);
        check("t3 run fell once", n_fall - f0, 1);

        // 4: reset mid-transfer
        base = n_wr;
        push_run(8'hC2, 10, 0, 1'b0);
        cpu_write(16'hFF46, 8'hC2);
        for (k = 0; k < 1000 && n_wr < base + 10; k++) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t4 run", dma_run, 0);
        check("t4 ndma", oam_addr_ndma, 1);
        check("t4 dma_a", dma_a, 16'hFF00);
        check("t4 reg_q", reg_q, 8'hFF);
        check("t4 wr", dma_wr, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("t4 stays idle", dma_run, 0);
        check("t4 bytes before reset", n_wr - base, 10);

        // 5: write coincident with mcyc, then mcyc held low
        @(posedge clk); #2;
        mcyc_en = 1'b0; mcyc = 1'b0;
        @(posedge clk); #1;
        cpu_a = 16'hFF46; cpu_d = 8'hC3; cpu_wr = 1'b1; mcyc = 1'b1;
        @(posedge clk); #1;
        cpu_wr = 1'b0; mcyc = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (dma_run || dma_wr) bad = 1'b1;
        end
        check("t5 frozen without mcyc", bad, 0);
        check("t5 reg_q", reg_q, 8'hC3);
        push_run(8'hC3, 160, 0, 1'b0);
        div = 0; mcyc_en = 1'b1;
        wait_mcyc("t5 first mcyc");
        @(negedge clk);
        check("t5 starts on first mcyc", dma_run, 1);
        wait_done("t5");

        // 6: neighbouring registers and foreign reads
        base = n_wr;
        cpu_write(16'hFF45, 8'h12);
        cpu_write(16'hFF47, 8'h34);
        cpu_a = 16'hFF45; cpu_rd = 1'b1; #1;
        check("t6 oe FF45", reg_oe, 0);
        cpu_a = 16'h0000; #1;
        check("t6 oe 0000", reg_oe, 0);
        cpu_a = 16'hFF46; cpu_rd = 1'b0; #1;
        check("t6 oe no rd", reg_oe, 0);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (dma_run) bad = 1'b1;
        end
        check("t6 no trigger", bad, 0);
        check("t6 src unchanged", reg_q, 8'hC3);
        check("t6 no writes", n_wr - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
